// File: rtl/ps2_scan_rx_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: frame geometry,
// special scan codes, receiver state encoding and frame validation.
package ps2_scan_rx_pkg;

   localparam int unsigned PS2_FRAME_BITS = 11;
   localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;
   localparam logic [7:0]  PS2_EXT_CODE   = 8'hE0;

   // Receiver is either waiting for a start edge or partway through a frame
   typedef enum logic {
      RX_IDLE  = 1'b0,
      RX_FRAME = 1'b1
   } rx_state_e;

   typedef logic [3:0] bit_cnt_t;

   // Frame layout: [0] start, [8:1] D7..D0, [9] odd parity, [10] stop
   function automatic logic frame_good(input logic [10:0] frame);
      return (frame[0] == 1'b0) && (frame[10] == 1'b1) && (^frame[9:1] == 1'b1);
   endfunction

   // True for the prefix bytes that precede a break or extended code
   function automatic logic is_prefix_code(input logic [7:0] code);
      return (code == PS2_BREAK_CODE) || (code == PS2_EXT_CODE);
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Three-flop synchronizers for the PS/2 clock and data lines, with a
// falling-edge pulse on the clock line and the data bit aligned to it.
module ps2_sync_edge (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic fall_o,
   output logic din_o
);

   // Bit 0 is the newest sample, bit 2 the oldest
   logic [2:0] clk_sync_q;
   logic [2:0] dat_sync_q;

   // Shift both raw lines in; reset to the PS/2 idle-high level
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
      end else begin
         clk_sync_q <= {clk_sync_q[1:0], ps2_clk_i};
         dat_sync_q <= {dat_sync_q[1:0], ps2_data_i};
      end
   end

   // Falling edge: older stage still high, newer stage already low
   always_comb begin
      fall_o = clk_sync_q[2] & ~clk_sync_q[1];
      din_o  = dat_sync_q[2];
   end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronizes the serial pair, assembles 11-bit
// frames with a mid-frame idle timeout, and buffers good scan codes in a
// small FIFO popped with an active-low request.
module ps2_scan_rx #(
   parameter int FIFO_DEPTH  = 8,
   parameter int PTR_W       = 3,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic       parity_err
);

   import ps2_scan_rx_pkg::*;

   localparam int       IDLE_W   = $clog2(TIMEOUT_CYC + 1);
   localparam bit_cnt_t LAST_BIT = bit_cnt_t'(PS2_FRAME_BITS - 1);

   // ---------------------------------------------------------------
   // Synchronizer / edge detector
   // ---------------------------------------------------------------
   logic fall;
   logic din;

   ps2_sync_edge u_sync (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .ps2_clk_i  (ps2_clk),
      .ps2_data_i (ps2_data),
      .fall_o     (fall),
      .din_o      (din)
   );

   // ---------------------------------------------------------------
   // Frame assembler
   // ---------------------------------------------------------------
   rx_state_e         state_q, state_d;
   bit_cnt_t          cnt_q, cnt_d;
   logic [9:0]        buf_q, buf_d;
   logic [IDLE_W-1:0] idle_q, idle_d;

   logic       frame_done;
   logic       frame_ok;
   logic       push;
   logic       bad_frame;
   logic [7:0] push_code;

   // Receiver state, bit counter, captured bits and idle timer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
         idle_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         idle_q  <= idle_d;
      end
   end

   // Capture one bit per falling edge; abandon the frame after a long stall
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      idle_d  = idle_q;
      unique case (state_q)
         RX_IDLE: begin
            idle_d = '0;
            if (fall) begin
               buf_d[0] = din;
               cnt_d    = bit_cnt_t'(1);
               state_d  = RX_FRAME;
            end
         end
         RX_FRAME: begin
            if (fall) begin
               idle_d = '0;
               if (cnt_q == LAST_BIT) begin
                  // Stop bit is judged straight off din, never stored
                  cnt_d   = '0;
                  state_d = RX_IDLE;
               end else begin
                  buf_d[cnt_q] = din;
                  cnt_d        = cnt_q + bit_cnt_t'(1);
               end
            end else if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
               cnt_d   = '0;
               idle_d  = '0;
               state_d = RX_IDLE;
            end else begin
               idle_d = idle_q + IDLE_W'(1);
            end
         end
         default: begin
            state_d = RX_IDLE;
            cnt_d   = '0;
            idle_d  = '0;
         end
      endcase
   end

   // Judge the frame on the edge that delivers its stop bit
   always_comb begin
      frame_done = (state_q == RX_FRAME) && fall && (cnt_q == LAST_BIT);
      frame_ok   = frame_good({din, buf_q});
      push       = frame_done && frame_ok;
      bad_frame  = frame_done && !frame_ok;
      push_code  = buf_q[8:1];
   end

   // One-cycle error pulse following a rejected frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= bad_frame;
      end
   end

   // ---------------------------------------------------------------
   // Scan-code FIFO
   // ---------------------------------------------------------------
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             overflow_q, overflow_d;

   logic full;
   logic pop;
   logic wr_en;
   logic drop;

   // A full FIFO still accepts a push when the head leaves in the same cycle
   always_comb begin
      full       = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
      pop        = !nextdata_n && (count_q != '0);
      wr_en      = push && (!full || pop);
      drop       = push && full && !pop;
      wr_ptr_d   = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d    = count_q;
      if (wr_en && !pop) begin
         count_d = count_q + (PTR_W + 1)'(1);
      end else if (pop && !wr_en) begin
         count_d = count_q - (PTR_W + 1)'(1);
      end
      overflow_d = overflow_q | drop;
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // FIFO storage, cleared on reset so an empty head reads as zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[wr_ptr_q] <= push_code;
      end
   end

   // Head entry and status outputs
   always_comb begin
      data     = mem_q[rd_ptr_q];
      ready    = (count_q != '0);
      overflow = overflow_q;
   end

endmodule
